// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences RV32I instructions through fetch/decode/execute/memory/writeback for a shared-ALU, unified-memory core
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               reg_write,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] state
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  state_t st, nxt;
  logic [2:0] funct_alu;
  logic [1:0] imm_dec;
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= FETCH;
    else st <= nxt;
  assign state = STATE_W'(st);
  always_comb begin
    funct_alu = funct3 == 3'b000 ? ((opcode == OP_R && funct7_5) ? 3'b001 : 3'b000) :
                funct3 == 3'b001 ? 3'b100 :
                funct3 == 3'b010 ? 3'b101 :
                funct3 == 3'b110 ? 3'b011 :
                funct3 == 3'b111 ? 3'b010 : 3'b000;
    imm_dec = opcode == OP_SW ? 2'b01 : opcode == OP_BEQ ? 2'b10 : opcode == OP_JAL ? 2'b11 : 2'b00;
  end
  // Every output is forced idle while reset is high, so nothing leaks from the FETCH decode.
  always_comb begin
    nxt           = FETCH;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    imm_src       = 2'b00;
    alu_control   = 3'b000;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    if (!reset) begin
      imm_src = imm_dec;
      case (st)
        FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          nxt        = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          nxt = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                opcode == OP_R   ? EXECUTER :
                opcode == OP_I   ? EXECUTEI :
                opcode == OP_BEQ ? BEQ :
                opcode == OP_JAL ? JAL : FETCH;
          illegal_instr = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          nxt       = opcode[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          adr_src = 1'b1;
          nxt     = mem_ready ? MEMWB : MEMREAD;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
          nxt       = mem_ready ? FETCH : MEMWRITE;
        end
        EXECUTER: begin
          alu_src_a   = 2'b10;
          alu_control = funct_alu;
          nxt         = ALUWB;
        end
        EXECUTEI: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = funct_alu == 3'b001 ? 3'b000 : funct_alu;
          nxt         = ALUWB;
        end
        ALUWB: reg_write = 1'b1;
        BEQ: begin
          alu_src_a   = 2'b10;
          alu_control = 3'b001;
          pc_write    = zero;
        end
        JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          nxt       = ALUWB;
        end
        default: imm_src = 2'b00;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: checks the controller against an instruction-level step-plan model
module tb_multicycle_control_fsm;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  int passed = 0, total = 0;
  int mr_q[$];
  int stall_run = 0;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .reg_write(reg_write), .illegal_instr(illegal_instr),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int funct_op(logic [6:0] op, logic [2:0] f3, logic f75);
    case (f3)
      3'd0: return (op == 7'h33 && f75) ? 1 : 0;
      3'd1: return 4;
      3'd2: return 5;
      3'd6: return 3;
      3'd7: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int imm_of(logic [6:0] op);
    return op == 7'h23 ? 1 : op == 7'h63 ? 2 : op == 7'h6F ? 3 : 0;
  endfunction

  function automatic bit legal(logic [6:0] op);
    return op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F};
  endfunction

  task automatic check_idle(string tag);
    check({tag, " state"}, state, 0);
    check({tag, " pc_write"}, pc_write, 0);
    check({tag, " ir_write"}, ir_write, 0);
    check({tag, " mem_write"}, mem_write, 0);
    check({tag, " reg_write"}, reg_write, 0);
    check({tag, " illegal"}, illegal_instr, 0);
    check({tag, " sels"}, {adr_src, result_src, alu_src_a, alu_src_b, imm_src}, 0);
    check({tag, " alu_control"}, alu_control, 0);
  endtask

  // Expected outputs for step s (spec state number) under the currently applied inputs
  task automatic step_check(int s);
    string t = $sformatf("s%0d op%02h", s, opcode);
    int alu_exp;
    alu_exp = s == 6 ? funct_op(opcode, funct3, funct7_5) :
              s == 8 ? (funct_op(opcode, funct3, funct7_5) == 1 ? 0 : funct_op(opcode, funct3, funct7_5)) :
              s == 10 ? 1 : 0;
    check({t, " state"}, state, s);
    check({t, " pc_write"}, pc_write, int'((s == 0 && mem_ready) || (s == 10 && zero) || s == 9));
    check({t, " ir_write"}, ir_write, int'(s == 0 && mem_ready));
    check({t, " adr_src"}, adr_src, int'(s inside {3, 5}));
    check({t, " mem_write"}, mem_write, int'(s == 5));
    check({t, " reg_write"}, reg_write, int'(s inside {4, 7}));
    check({t, " result_src"}, result_src, s == 0 ? 2 : s == 4 ? 1 : 0);
    check({t, " alu_src_a"}, alu_src_a, s inside {1, 9} ? 1 : s inside {2, 6, 8, 10} ? 2 : 0);
    check({t, " alu_src_b"}, alu_src_b, s inside {0, 9} ? 2 : s inside {1, 2, 8} ? 1 : 0);
    check({t, " alu_control"}, alu_control, alu_exp);
    check({t, " imm_src"}, imm_src, imm_of(opcode));
    check({t, " illegal"}, illegal_instr, int'(s == 1 && !legal(opcode)));
  endtask

  // Called at posedge+1 with the controller in FETCH; runs one whole instruction
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic f75, logic z);
    int plan[$];
    int cycles = 0, stalls = 0, base;
    bit stalled;
    case (op)
      7'h03: begin plan = {0, 1, 2, 3, 4}; base = 5; end
      7'h23: begin plan = {0, 1, 2, 5}; base = 4; end
      7'h33: begin plan = {0, 1, 6, 7}; base = 4; end
      7'h13: begin plan = {0, 1, 8, 7}; base = 4; end
      7'h63: begin plan = {0, 1, 10}; base = 3; end
      7'h6F: begin plan = {0, 1, 9, 7}; base = 4; end
      default: begin plan = {0, 1}; base = 2; end
    endcase
    opcode = op; funct3 = f3; funct7_5 = f75; zero = z;
    foreach (plan[i]) begin
      do begin
        if (mr_q.size() > 0) mem_ready = mr_q.pop_front() != 0;
        else mem_ready = ($urandom_range(3) != 0) || stall_run >= 3;
        @(negedge clk);
        step_check(plan[i]);
        cycles++;
        stalled = (plan[i] inside {0, 3, 5}) && !mem_ready;
        if (stalled) begin stalls++; stall_run++; end
        else stall_run = 0;
        @(posedge clk); #1;
      end while (stalled);
    end
    check($sformatf("cycles op%02h", op), cycles, base + stalls);
  endtask

  initial begin
    logic [6:0] ops[7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h7F};
    reset = 1'b1; mem_ready = 1'b1; opcode = 7'h23;
    repeat (2) @(posedge clk);
    #1 check_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check("rst_seq s0", state, 0);
    check("rst_seq ir_write", ir_write, 1);
    @(posedge clk); #1;
    @(negedge clk); check("rst_seq s1", state, 1);
    @(posedge clk); #1;
    @(negedge clk); check("rst_seq s2", state, 2);
    @(posedge clk); #1 mem_ready = 1'b0;
    @(negedge clk);
    check("rst_seq s5", state, 5);
    check("rst_seq mem_write", mem_write, 1);
    #2 reset = 1'b1; mem_ready = 1'b1;
    #1 check_idle("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_idle("held_rst");
    end
    @(posedge clk); #1 reset = 1'b0;
    mr_q = {0, 1};
    run_instr(7'h23, 3'b010, 1'b0, 1'b0);
    mr_q = {0, 0, 1, 1, 1, 0, 1, 1};
    run_instr(7'h03, 3'b010, 1'b0, 1'b0);
    run_instr(7'h33, 3'b000, 1'b1, 1'b0);
    run_instr(7'h33, 3'b111, 1'b0, 1'b1);
    run_instr(7'h13, 3'b000, 1'b1, 1'b0);
    run_instr(7'h13, 3'b001, 1'b0, 1'b0);
    mr_q = {1, 1, 1};
    run_instr(7'h63, 3'b000, 1'b0, 1'b1);
    mr_q = {1, 1, 1};
    run_instr(7'h63, 3'b000, 1'b0, 1'b0);
    run_instr(7'h6F, 3'b000, 1'b0, 1'b0);
    run_instr(7'h7F, 3'b000, 1'b0, 1'b0);
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(6)], 3'($urandom), 1'($urandom), 1'($urandom));
    run_instr(7'h13, 3'b110, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Sequencing controller for the multi-cycle variant of the RV32I core, which shares one ALU and one unified instruction/data memory across cycles.
- Steps each instruction through Fetch/Decode/Execute/Memory/Writeback states.
- Drives per-cycle mux selects and write enables.
- Stalls on a memory-ready handshake.
- Supports lw, sw, R-type (add/sub/and/or/slt/sll), I-type ALU (addi/andi/ori/slti/slli), beq and jal.

Parameters:
STATE_W, 4, width of state register and debug state output

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces FETCH
opcode  input  7  instruction[6:0] from instruction register
funct3  input  3  instruction[14:12]
funct7_5  input  1  instruction[30]
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed the current read/write this cycle
pc_write  output  1  PC register load enable
adr_src  output  1  memory address: 0=PC, 1=result bus
mem_write  output  1  memory write request
ir_write  output  1  load instruction and old-PC registers
result_src  output  2  00=ALUOut reg, 01=read data, 10=ALU result
alu_src_a  output  2  00=PC, 01=old PC, 10=rs1 data
alu_src_b  output  2  00=rs2 data, 01=immediate, 10=constant 4
imm_src  output  2  00=I, 01=S, 10=B, 11=J
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 sll, 101 slt
reg_write  output  1  register file write enable
illegal_instr  output  1  one-cycle pulse on unsupported opcode
state  output  STATE_W  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 return to FETCH with all enables 0.
- Reset: state=FETCH immediately. While reset is high, all enables (pc_write, mem_write, ir_write, reg_write, illegal_instr) are 0. Selects are 0 and alu_control=000.
- Reset mid-instruction: the in-flight instruction is abandoned with no partial writes. The first fetch begins on the first clk edge after deassertion.
- Outputs are Moore (decoded from state), except:
  - pc_write in BEQ
  - ir_write/pc_write in FETCH
  - alu_control and imm_src, which also depend on the instruction fields.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
  - Hold until mem_ready=1.
  - In that cycle only: ir_write=1, pc_write=1, then go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target precompute). imm_src follows opcode. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other -> FETCH, with illegal_instr=1 in this DECODE cycle only
- MEMADR: alu_src_a=10, alu_src_b=01, add. Go to MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. mem_write stays high every cycle until mem_ready=1, then FETCH.
- EXECUTER: alu_src_a=10, alu_src_b=00, ALU op per funct decode, then ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, funct decode (never sub), then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00. pc_write=zero. Next state FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Then ALUWB (rd = PC+4).
- Funct decode:
  - funct3 000: sub if opcode=0110011 and funct7_5=1, else add
  - 001: sll
  - 010: slt
  - 110: or
  - 111: and
  - other: add
- imm_src: sw=01, beq=10, jal=11, else 00.
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE.
- No combinational path from mem_ready to state. The transition is registered on the edge.
- Cycle counts with mem_ready always 1:
  - lw = 5
  - sw = 4
  - R/I = 4
  - beq = 3
  - jal = 4

Test Plan:
- Reset held 3 cycles mid-MEMWRITE, then released -> state=0 asynchronously, mem_write=0 immediately; the first FETCH asserts ir_write only when mem_ready=1.
- lw (0x00402083) with mem_ready low 2 cycles in FETCH and 1 in MEMREAD -> states 0,0,0,1,2,3,3,4,0; reg_write=1 only in MEMWB with result_src=01.
- R-type sub (funct3=000, funct7_5=1) -> EXECUTER alu_control=001; addi with funct7_5=1 -> EXECUTEI alu_control=000; slli -> 100.
- beq with zero=1, then zero=0 -> pc_write=1 in BEQ for the first case, 0 for the second; both return to FETCH in 3 cycles.
- jal -> DECODE imm_src=11, JAL pc_write=1 alu_src_a=01 alu_src_b=10, then ALUWB reg_write=1.
- Opcode 0x7F -> illegal_instr pulses exactly 1 cycle in DECODE, no reg_write/mem_write, next state FETCH.
